// File: rtl/regfile_pkg.sv
// Shared types and constants for the pipeline register file and its debug dump port.
package regfile_pkg;

  localparam int REG_NUM_LOG2 = 5;
  localparam int REG_NUM      = 32;
  localparam int REG_WIDTH    = 32;

  typedef logic [REG_WIDTH-1:0]    reg_bus_t;
  typedef logic [REG_NUM_LOG2-1:0] reg_addr_bus_t;

  localparam reg_bus_t ZERO_WORD = '0;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

  // Reset is active-low throughout this block.
  localparam logic RST_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_SCAN = 2'd1,
    DUMP_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_seq.sv
// Dump sequencer: walks every register index once under a valid/ready handshake.
//
// state     | meaning
// ----------+------------------------------------------------------------
// DUMP_IDLE | waiting for dump_req; pointer parked at 0
// DUMP_SCAN | presenting entry [pointer]; advances on dump_ready
// DUMP_DONE | one-cycle dump_done pulse, then back to idle
module regfile_dump_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REG_NUM_LOG2,
  parameter int NREGS  = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dump_req,
  input  logic              dump_ready,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic              dump_done,
  output logic [ADDR_W-1:0] dump_addr
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q <= DUMP_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    dump_busy  = 1'b0;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    unique case (state_q)
      DUMP_IDLE: begin
        if (dump_req) begin
          state_d = DUMP_SCAN;
          ptr_d   = '0;
        end
      end
      DUMP_SCAN: begin
        dump_busy  = 1'b1;
        dump_valid = 1'b1;
        if (dump_ready) begin
          ptr_d = ptr_q + 1'b1;
          // Last entry accepted: single pass only, no wrap into a second scan.
          if (ptr_q == ADDR_W'(NREGS - 1)) begin
            state_d = DUMP_DONE;
          end
        end
      end
      DUMP_DONE: begin
        dump_busy = 1'b1;
        dump_done = 1'b1;
        state_d   = DUMP_IDLE;
        ptr_d     = '0;
      end
      default: begin
        state_d = DUMP_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign dump_addr = ptr_q;

endmodule

// File: rtl/regfile.sv
// 32x32 MIPS register file: r0 reads as zero, two combinational read ports with
// write-back bypass, clocked write port, and a serial dump port for debug.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = REG_WIDTH,
  parameter int ADDR_W = REG_NUM_LOG2,
  parameter int NREGS  = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we == WRITE_ENABLE && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // Shared by both read ports and the dump port so all three see identical bypass behaviour.
  function automatic logic [DATA_W-1:0] read_mux(input logic en, input logic [ADDR_W-1:0] addr);
    if (rst == RST_ACTIVE) begin
      return DATA_W'(ZERO_WORD);
    end else if (en == READ_DISABLE) begin
      return DATA_W'(ZERO_WORD);
    end else if (addr == '0) begin
      return DATA_W'(ZERO_WORD);
    end else if (we == WRITE_ENABLE && waddr == addr) begin
      return wdata;
    end else begin
      return regs[addr];
    end
  endfunction

  always_comb begin
    rdata1    = read_mux(re1, raddr1);
    rdata2    = read_mux(re2, raddr2);
    dump_data = read_mux(dump_valid, dump_addr);
  end

  regfile_dump_seq #(
    .ADDR_W(ADDR_W),
    .NREGS (NREGS)
  ) u_dump_seq (
    .clk       (clk),
    .rst       (rst),
    .dump_req  (dump_req),
    .dump_ready(dump_ready),
    .dump_busy (dump_busy),
    .dump_valid(dump_valid),
    .dump_done (dump_done),
    .dump_addr (dump_addr)
  );

endmodule

// File: tb/tb_regfile.sv
// Randomised scoreboard bench for regfile: a register-array model predicts every cycle's
// read-port and dump-status outputs, plus each dump entry handed over on a handshake.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;
  logic        dump_req = 1'b0;
  logic        dump_busy;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_done;

  regfile dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .dump_req  (dump_req),
    .dump_busy (dump_busy),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .dump_done (dump_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        busy;
    logic        valid;
    logic        done;
  } rec_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } dent_t;

  rec_t  q_rec[$];
  dent_t q_dump[$];

  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  int m_acc = 0;

  // Reference model: register contents plus dump progress (0 idle, 1 scanning, 2 finishing).
  logic [31:0] mem [32];
  int          m_state = 0;
  int          m_ptr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mref(input logic en, input logic [4:0] a, input logic w,
                                       input logic [4:0] wa, input logic [31:0] wd);
    if (!en || a == 5'd0) return 32'd0;
    if (w && wa == a) return wd;
    return mem[a];
  endfunction

  task automatic step(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                      input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                      input logic rq, input logic rdy);
    rec_t e;
    @(posedge clk);
    #1;
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    dump_req = rq; dump_ready = rdy;
    if (!r) begin
      e = '0;
      q_rec.push_back(e);
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
      m_state = 0;
      m_ptr = 0;
      return;
    end
    e.r1    = mref(e1, a1, w, wa, wd);
    e.r2    = mref(e2, a2, w, wa, wd);
    e.busy  = (m_state != 0);
    e.valid = (m_state == 1);
    e.done  = (m_state == 2);
    q_rec.push_back(e);
    case (m_state)
      0: if (rq) begin m_state = 1; m_ptr = 0; end
      1: if (rdy) begin
           q_dump.push_back('{addr: 5'(m_ptr), data: mref(1'b1, 5'(m_ptr), w, wa, wd)});
           m_acc++;
           m_ptr++;
           if (m_ptr == 32) m_state = 2;
         end
      default: begin m_state = 0; m_ptr = 0; end
    endcase
    if (w && wa != 5'd0) mem[wa] = wd;
  endtask

  task automatic idle_rd(input logic [4:0] a1, input logic [4:0] a2, input logic rdy);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, a1, 1'b1, a2, 1'b0, rdy);
  endtask

  always @(negedge clk) begin
    rec_t  e;
    dent_t d;
    if (q_rec.size() > 0) begin
      e = q_rec.pop_front();
      chk("rdata1", rdata1, e.r1);
      chk("rdata2", rdata2, e.r2);
      chk("dump_busy", {31'd0, dump_busy}, {31'd0, e.busy});
      chk("dump_valid", {31'd0, dump_valid}, {31'd0, e.valid});
      chk("dump_done", {31'd0, dump_done}, {31'd0, e.done});
    end
    if (dump_valid && dump_ready) begin
      n_acc++;
      if (q_dump.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL dump_unexpected actual=addr %0d required=no entry", dump_addr);
      end else begin
        d = q_dump.pop_front();
        chk("dump_addr", {27'd0, dump_addr}, {27'd0, d.addr});
        chk("dump_data", dump_data, d.data);
      end
    end
  end

  initial begin
    int acc0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;

    // Held in reset with reads enabled: everything reads zero.
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd3, 32'hAAAA_5555, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0);
    idle_rd(5'd3, 5'd0, 1'b0);

    // Write then read back; disabled port reads zero.
    step(1'b1, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0);

    // Same-cycle bypass on both ports.
    step(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
    idle_rd(5'd7, 5'd5, 1'b0);

    // r0 write is discarded, bypass included.
    step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    idle_rd(5'd0, 5'd0, 1'b0);

    // Preload rk = k*0x11, then dump with alternating ready and a stray mid-scan request.
    for (int k = 1; k < 32; k++) begin
      step(1'b1, 1'b1, 5'(k), 32'(k * 32'h11), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    end
    acc0 = n_acc;
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 70; i++) begin
      step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'($urandom), 1'b1, 5'($urandom),
           (i == 9), (i % 2 == 0));
    end
    @(negedge clk);
    #1;
    chk("dump1_count", 32'(n_acc - acc0), 32'd32);

    // Random traffic with dumps, back-pressure and writes racing the scan.
    for (int i = 0; i < 2000; i++) begin
      step(1'b1, 1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom),
           1'($urandom), 5'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < 100 && m_state != 0; i++) idle_rd(5'd1, 5'd2, 1'b1);

    // Reset right after entry 10 is accepted: abort with no done pulse, registers cleared.
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    for (int i = 0; i < 50 && !(m_state == 1 && m_ptr == 11); i++) idle_rd(5'd4, 5'd9, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd9, 1'b0, 1'b1);
    for (int k = 0; k < 32; k++) idle_rd(5'(k), 5'(31 - k), 1'b1);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    for (int i = 0; i < 36; i++) idle_rd(5'(i), 5'd31, 1'b1);

    idle_rd(5'd0, 5'd0, 1'b0);
    @(negedge clk);
    #1;
    chk("dump_total", 32'(n_acc), 32'(m_acc));
    chk("dump_queue_left", 32'(q_dump.size()), 32'd0);
    chk("rec_queue_left", 32'(q_rec.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- General-purpose register file of the 5-stage MIPS pipeline. It is the responder to the decode stage's two read-request ports (read enable, address) and the sink of the write-back port (write enable, address, data).
- 32 x 32-bit registers; r0 is hardwired to zero. Reads are same-cycle combinational with write-to-read bypass. The write is clocked.
- A serial dump port streams all registers out under a valid/ready handshake, for debug and for bench checking.

Parameters:
DATA_W, 32, register width
ADDR_W, 5, register address width
NREGS, 32, number of registers (= 2**ADDR_W)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low (0 = reset)
we  in  1  write-back enable
waddr  in  ADDR_W  write-back register address
wdata  in  DATA_W  write-back data
re1  in  1  read port 1 enable
raddr1  in  ADDR_W  read port 1 address
rdata1  out  DATA_W  read port 1 data (combinational)
re2  in  1  read port 2 enable
raddr2  in  ADDR_W  read port 2 address
rdata2  out  DATA_W  read port 2 data (combinational)
dump_req  in  1  start-dump pulse
dump_busy  out  1  dump in progress
dump_valid  out  1  dump_addr/dump_data are valid
dump_ready  in  1  consumer accepts the current dump entry
dump_addr  out  ADDR_W  index of the current dump entry
dump_data  out  DATA_W  value of the current dump entry
dump_done  out  1  one-cycle pulse after the last entry is accepted

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers clear to 0;
  - dump FSM goes to IDLE; pointer = 0;
  - dump_busy, dump_valid and dump_done = 0; dump_addr = 0.
  - rdata1/rdata2 are forced to 0 while rst=0.
- Write:
  - on the rising clk edge with we=1 and waddr!=0, regs[waddr] <= wdata.
  - A write to address 0 is discarded.
- Read port n (n = 1, 2), priority order:
  1. rst=0 -> 0.
  2. ren=0 -> 0.
  3. raddrn=0 -> 0.
  4. we=1 and waddr==raddrn -> wdata (same-cycle bypass).
  5. Otherwise -> regs[raddrn].
  - Both ports are independent; both may hit the same address or the bypass simultaneously.
- Read latency is 0 cycles; write-to-visible-in-array latency is 1 edge, but data is visible at once through the bypass.
- Dump FSM, states IDLE, SCAN, DONE:
  - IDLE: dump_req=1 -> SCAN at the next edge, pointer=0. dump_req while not in IDLE is ignored (no queuing).
  - SCAN: dump_valid=1, dump_addr=pointer, dump_data = live value of the pointer register, using the same bypass rule as the read ports (entry 0 always 0).
    - dump_valid && dump_ready -> pointer+1.
    - Accepting entry NREGS-1 -> DONE (no wrap into a second pass).
    - dump_ready=0 stalls: pointer holds. dump_data may change during a stall if that register is written; the consumer samples on the handshake edge.
  - DONE: dump_done=1 for exactly one cycle, dump_valid=0 -> IDLE. A dump_req in DONE is ignored.
  - dump_busy=1 in SCAN and DONE.
- Writes and reads continue normally during a dump. An entry already accepted is not re-sent if later overwritten.
- Reset mid-dump aborts at once; no dump_done is issued.
- A full dump with dump_ready held high takes 1 (request) + 32 (SCAN) + 1 (DONE) cycles.

Decomposition:
- Shared defines file holds:
  - RegBus, RegAddrBus, RegNum (32), RegNumLog2 (5), ZeroWord;
  - WriteEnable/Disable, ReadEnable/Disable;
  - the reset-active level for the active-low reset;
  - dump state encodings.
- One natural sub-module: regfile_dump_seq. It holds the FSM, pointer and handshake, and drives an address into a third read mux owned by regfile.

Test Plan:
- Reset then read: rst=0 -> 1, re1=re2=1, raddr1=3, raddr2=0 -> rdata1=0, rdata2=0, dump_busy=0.
- Write and read back: write r5=0x1234_5678 (1 edge), then re1=1, raddr1=5 -> 0x1234_5678. re1=0 with the same address -> 0.
- Bypass: in the same cycle we=1, waddr=7, wdata=0xDEAD_BEEF, re1=re2=1, raddr1=raddr2=7 -> both ports read 0xDEAD_BEEF before the edge.
- r0 protection: write r0=0xFFFF_FFFF -> read r0 = 0, including the same-cycle bypass case. Dump entry 0 = 0.
- Dump with back-pressure:
  - Preload rk = k*0x11.
  - Pulse dump_req, then toggle dump_ready 1,0,1,...
  - Required: 32 accepted entries, addr 0..31 in order, data k*0x11 (entry 0 = 0), then exactly one dump_done pulse, then dump_busy=0. A second dump_req mid-scan is ignored.
- Reset mid-dump: assert rst after entry 10 is accepted -> dump_valid=0 and dump_busy=0 immediately, all registers 0, no dump_done pulse.
